unified_buffer: RTL

Parametrised simple-dual-port unified buffer holding activations and partial results for the vector multiplier datapath. It replaces the single-port store with independent write and read ports, per-byte write masking, a valid-qualified read pipeline with selectable latency, and a burst-read engine that streams consecutive words to the array feeder without per-word addressing.

---
 rtl/unified_buffer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/unified_buffer.sv
// unified_buffer: simple-dual-port activation / partial-result store for the
// vector multiplier datapath. Independent write and read ports, byte-masked
// writes, valid-qualified read pipeline (latency 1 + OUT_REG), and a burst-read
// engine that streams consecutive words with address wrap-around.
//
// Build option: define UB_BYPASS_EN to forward same-cycle write data into a
// read of the same address (merged word). Without it such a read returns the
// pre-write contents; the write still lands.
//
// state   | meaning
// S_IDLE  | single reads on rd_en accepted; burst_start with nonzero len arms a burst
// S_BURST | one read per cycle at consecutive addresses until the count expires

module unified_buffer #(
    parameter int ADDRESSSIZE = 10,
    parameter int WORDSIZE    = 160,
    parameter int OUT_REG     = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ADDRESSSIZE-1:0] wr_addr,
    input  logic [WORDSIZE-1:0]    wr_data,
    input  logic [WORDSIZE/8-1:0]  wr_mask,
    input  logic                   rd_en,
    input  logic [ADDRESSSIZE-1:0] rd_addr,
    input  logic                   burst_start,
    input  logic [ADDRESSSIZE-1:0] burst_base,
    input  logic [ADDRESSSIZE:0]   burst_len,
    output logic [WORDSIZE-1:0]    rd_data,
    output logic                   rd_valid,
    output logic                   burst_busy,
    output logic                   burst_done
);

    localparam int BYTES = WORDSIZE / 8;
    localparam int DEPTH = 1 << ADDRESSSIZE;
    localparam logic [ADDRESSSIZE-1:0] ADDR_ONE = 1;
    localparam logic [ADDRESSSIZE:0]   CNT_ONE  = 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDRESSSIZE-1:0] r_burst_addr;
    logic [ADDRESSSIZE-1:0] w_burst_addr_nxt;
    logic [ADDRESSSIZE:0]   r_burst_cnt;
    logic [ADDRESSSIZE:0]   w_burst_cnt_nxt;

    logic                   w_issue;
    logic                   w_issue_last;
    logic [ADDRESSSIZE-1:0] w_issue_addr;
    logic [WORDSIZE-1:0]    w_rd_word;

    logic [WORDSIZE-1:0]    r_mem [DEPTH];

    logic                   r_v1;
    logic                   r_last1;
    logic [WORDSIZE-1:0]    r_d1;

    // State register and burst address / remaining-count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_burst_addr <= '0;
            r_burst_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_burst_addr <= w_burst_addr_nxt;
            r_burst_cnt  <= w_burst_cnt_nxt;
        end
    end

    // Next-state logic and read-issue selection (burst owns the read port while busy)
    always_comb begin
        w_state_nxt      = r_state;
        w_burst_addr_nxt = r_burst_addr;
        w_burst_cnt_nxt  = r_burst_cnt;
        w_issue          = 1'b0;
        w_issue_last     = 1'b0;
        w_issue_addr     = rd_addr;
        burst_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_issue = rd_en;
                if (burst_start && (burst_len != '0)) begin
                    w_state_nxt      = S_BURST;
                    w_burst_addr_nxt = burst_base;
                    w_burst_cnt_nxt  = burst_len;
                end
            end
            S_BURST: begin
                burst_busy       = 1'b1;
                w_issue          = 1'b1;
                w_issue_addr     = r_burst_addr;
                w_burst_addr_nxt = r_burst_addr + ADDR_ONE;
                w_burst_cnt_nxt  = r_burst_cnt - CNT_ONE;
                if (r_burst_cnt == CNT_ONE) begin
                    w_issue_last = 1'b1;
                    w_state_nxt  = S_IDLE;
                end
            end
        endcase
    end

    // Byte-masked write port; the array itself is never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_mask[b]) begin
                    r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Word presented to the read pipeline, optionally merged with a same-address write
    always_comb begin
        w_rd_word = r_mem[w_issue_addr];
`ifdef UB_BYPASS_EN
        if (wr_en && (wr_addr == w_issue_addr)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (wr_mask[b]) begin
                    w_rd_word[8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
`endif
    end

    // First read stage: data only updates on an issued read so it holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_d1    <= '0;
        end else begin
            r_v1    <= w_issue;
            r_last1 <= w_issue_last;
            if (w_issue) begin
                r_d1 <= w_rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                r_v2;
        logic                r_last2;
        logic [WORDSIZE-1:0] r_d2;

        // Optional output register stage adding one cycle of read latency
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v2    <= 1'b0;
                r_last2 <= 1'b0;
                r_d2    <= '0;
            end else begin
                r_v2    <= r_v1;
                r_last2 <= r_v1 & r_last1;
                if (r_v1) begin
                    r_d2 <= r_d1;
                end
            end
        end

        assign rd_data    = r_d2;
        assign rd_valid   = r_v2;
        assign burst_done = r_last2;
    end else begin : g_no_out_reg
        assign rd_data    = r_d1;
        assign rd_valid   = r_v1;
        assign burst_done = r_v1 & r_last1;
    end

endmodule
